// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed hex display driver for the CPU debug word.
// The shadow register takes loads at any time; the frame register only changes at a frame boundary, so a frame never tears.
module seg7_scan_driver #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] disp_data,
    input  logic        disp_load,
    input  logic        sel_hi,
    input  logic        blank,
    output logic [6:0]  sm_duan,
    output logic [3:0]  sm_wei,
    output logic        frame_start
);

    localparam logic [CNT_W-1:0] TICK_AT = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] prescaler_q, prescaler_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [31:0]      frame_q, frame_d;
    logic             frame_hi_q, frame_hi_d;
    logic [6:0]       sm_duan_q, sm_duan_d;
    logic [3:0]       sm_wei_q, sm_wei_d;
    logic             frame_start_q, frame_start_d;

    logic             tick;
    logic             boundary;
    logic [15:0]      half;
    logic [3:0]       nibble;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    always_comb begin
        tick          = (prescaler_q == TICK_AT);
        prescaler_d   = tick ? '0 : prescaler_q + 1'b1;
        digit_idx_d   = tick ? digit_idx_q + 2'd1 : digit_idx_q;
        boundary      = tick && (digit_idx_q == 2'd3);

        shadow_d      = disp_load ? disp_data : shadow_q;
        frame_d       = boundary ? shadow_q : frame_q;
        frame_hi_d    = boundary ? sel_hi : frame_hi_q;
        frame_start_d = boundary;

        // Decode from the *next* frame contents so digit 0 of a new frame already shows new data.
        half = frame_hi_d ? frame_d[31:16] : frame_d[15:0];
        case (digit_idx_d)
            2'd0:    nibble = half[3:0];
            2'd1:    nibble = half[7:4];
            2'd2:    nibble = half[11:8];
            default: nibble = half[15:12];
        endcase

        sm_duan_d = sm_duan_q;
        sm_wei_d  = sm_wei_q;
        if (tick) begin
            if (blank) begin
                sm_duan_d = 7'b1111111;
                sm_wei_d  = 4'b1111;
            end else begin
                sm_duan_d = hex_to_seg(nibble);
                sm_wei_d  = ~(4'b0001 << digit_idx_d);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_q   <= '0;
            digit_idx_q   <= 2'd3;
            shadow_q      <= '0;
            frame_q       <= '0;
            frame_hi_q    <= 1'b0;
            sm_duan_q     <= 7'b1111111;
            sm_wei_q      <= 4'b1111;
            frame_start_q <= 1'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            digit_idx_q   <= digit_idx_d;
            shadow_q      <= shadow_d;
            frame_q       <= frame_d;
            frame_hi_q    <= frame_hi_d;
            sm_duan_q     <= sm_duan_d;
            sm_wei_q      <= sm_wei_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign sm_duan     = sm_duan_q;
    assign sm_wei      = sm_wei_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios then random traffic, checked against a cycle-count based display model.
module tb_seg7_scan_driver;

    localparam int SD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] disp_data;
    logic        disp_load;
    logic        sel_hi;
    logic        blank;
    logic [6:0]  sm_duan;
    logic [3:0]  sm_wei;
    logic        frame_start;

    always #5 clk = ~clk;

    seg7_scan_driver #(.SCAN_DIV(SD), .CNT_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .disp_data   (disp_data),
        .disp_load   (disp_load),
        .sel_hi      (sel_hi),
        .blank       (blank),
        .sm_duan     (sm_duan),
        .sm_wei      (sm_wei),
        .frame_start (frame_start)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: everything is derived from how many edges and ticks have passed since reset.
    logic [31:0] m_shadow, m_frame;
    logic        m_hi;
    int          m_cyc, m_ticks;
    logic [6:0]  m_duan;
    logic [3:0]  m_wei;
    logic        m_fs;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".duan"}, 32'(sm_duan), 32'(m_duan));
        chk({tag, ".wei"},  32'(sm_wei),  32'(m_wei));
        chk({tag, ".fs"},   32'(frame_start), 32'(m_fs));
    endtask

    task automatic m_reset();
        m_shadow = '0;
        m_frame  = '0;
        m_hi     = 1'b0;
        m_cyc    = 0;
        m_ticks  = 0;
        m_duan   = 7'b1111111;
        m_wei    = 4'b1111;
        m_fs     = 1'b0;
    endtask

    function automatic logic next_is_boundary();
        return ((m_cyc % SD) == SD - 1) && ((m_ticks % 4) == 0);
    endfunction

    task automatic step(input string tag);
        logic        ld, hi, bl, tick;
        logic [31:0] dd;
        logic [15:0] half;
        logic [3:0]  nib;
        int          dig;
        ld = disp_load; dd = disp_data; hi = sel_hi; bl = blank;
        @(posedge clk);
        tick = ((m_cyc % SD) == SD - 1);
        m_cyc++;
        m_fs = 1'b0;
        if (tick) begin
            m_ticks++;
            dig = (m_ticks - 1) % 4;
            if (dig == 0) begin
                m_frame = m_shadow;
                m_hi    = hi;
                m_fs    = 1'b1;
            end
            half = m_hi ? m_frame[31:16] : m_frame[15:0];
            nib  = 4'(half >> (4 * dig));
            if (bl) begin
                m_duan = 7'b1111111;
                m_wei  = 4'b1111;
            end else begin
                m_duan = seg_tab[nib];
                m_wei  = ~(4'b0001 << dig);
            end
        end
        if (ld) m_shadow = dd;
        #1;
        check_all(tag);
        $display("[TB] %s t=%0t load=%0b data=%h hi=%0b blank=%0b -> duan=%b wei=%b fs=%0b",
                 tag, $time, ld, dd, hi, bl, sm_duan, sm_wei, frame_start);
    endtask

    task automatic run(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        int waited;
        reset = 1'b1; disp_data = '0; disp_load = 1'b0; sel_hi = 1'b0; blank = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // 1: load at the first edge, lower half
        disp_data = 32'h1234ABCD; disp_load = 1'b1;
        step("t1_load");
        disp_load = 1'b0;
        run("t1_dark", 2);
        chk("t1_dark_wei", 32'(sm_wei), 32'h0000000F);
        step("t1_d0");
        chk("t1_digitD", 32'(sm_duan), 32'(7'b0100001));
        chk("t1_wei0", 32'(sm_wei), 32'(4'b1110));
        run("t1_scan", 16);

        // 2: upper half requested mid-frame
        run("t2_pre", 5);
        sel_hi = 1'b1;
        run("t2_scan", 24);

        // 3: load mid-frame must not tear the frame
        sel_hi = 1'b0;
        run("t3_pre", 18);
        disp_data = 32'hFFFF0000; disp_load = 1'b1;
        step("t3_load");
        disp_load = 1'b0;
        run("t3_scan", 24);

        // 4: load on the exact boundary edge
        waited = 0;
        while (!next_is_boundary() && waited < 20) begin
            step("t4_align");
            waited++;
        end
        chk("t4_aligned", 32'(next_is_boundary()), 32'd1);
        disp_data = 32'h5A5AC3C3; disp_load = 1'b1;
        step("t4_load");
        chk("t4_old_frame", 32'(sm_duan), 32'(7'b1000000));
        disp_load = 1'b0;
        run("t4_scan", 32);

        // 5: blanking
        blank = 1'b1;
        run("t5_blank", 34);
        blank = 1'b0;
        run("t5_resume", 20);

        // 6: asynchronous reset between edges
        run("t6_pre", 6);
        #3 reset = 1'b1;
        #1;
        m_reset();
        check_all("t6_async");
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;
        run("t6_dark", 3);
        step("t6_d0");
        chk("t6_wei0", 32'(sm_wei), 32'(4'b1110));
        chk("t6_zero", 32'(sm_duan), 32'(7'b1000000));
        chk("t6_fs", 32'(frame_start), 32'd1);

        // 7: random traffic
        for (int i = 0; i < 400; i++) begin
            disp_load = ($urandom_range(4) == 0);
            disp_data = $urandom;
            if ($urandom_range(9) == 0) sel_hi = ~sel_hi;
            if ($urandom_range(19) == 0) blank = ~blank;
            step("t7_rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
